// File: rtl/udma_uart_rx_core.sv
// UART receive engine: synchronises rx_i, deserialises one character per frame and
// hands it to the register interface through a one-entry valid/ready holding register.
module udma_uart_rx_core #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIV_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 rx_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic [1:0]           cfg_bits_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_stop_bits_i,
    output logic [7:0]           rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 err_parity_o,
    output logic                 err_overflow_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StStop2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_rx, s_rx_prev_q;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d, div_q, div_d, target;
    logic [1:0]             bits_q, bits_d;
    logic                   par_en_q, par_en_d, stop2_q, stop2_d;
    logic [2:0]             bit_idx_q, bit_idx_d, last_idx;
    logic [7:0]             shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic                   tick, deliver;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q, err_parity_q, err_overflow_q;

    assign s_rx     = sync_q[SYNC_STAGES-1];
    // START samples at mid-bit, every later state at full-period boundaries.
    assign target   = (state_q == StStart) ? (div_q >> 1) : div_q;
    assign tick     = (cnt_q == target);
    assign last_idx = 3'd4 + {1'b0, bits_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + DIV_WIDTH'(1);
        div_d     = div_q;
        bits_d    = bits_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        deliver   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cfg_en_i && s_rx_prev_q && !s_rx) begin
                    state_d  = StStart;
                    div_d    = cfg_div_i;
                    bits_d   = cfg_bits_i;
                    par_en_d = cfg_parity_en_i;
                    stop2_d  = cfg_stop_bits_i;
                end
            end
            StStart: begin
                if (tick) begin
                    if (!s_rx) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                        shift_d   = '0;
                        par_err_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d[bit_idx_q] = s_rx;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == last_idx) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    par_err_d = (^shift_q) ^ s_rx;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (s_rx) begin
                        deliver = 1'b1;
                        state_d = stop2_q ? StStop2 : StIdle;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StStop2: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!cfg_en_i) begin
            state_d = StIdle;
            deliver = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q      <= '1;
            s_rx_prev_q <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            div_q       <= '0;
            bits_q      <= '0;
            par_en_q    <= 1'b0;
            stop2_q     <= 1'b0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_i};
            s_rx_prev_q <= s_rx;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bits_q      <= bits_d;
            par_en_q    <= par_en_d;
            stop2_q     <= stop2_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
        end
    end

    // A delivery in the same cycle as a handshake replaces the consumed character.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            err_parity_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            err_parity_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            if (deliver) begin
                err_parity_q <= par_err_q;
                if (!rx_valid_q || rx_ready_i) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    err_overflow_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign err_parity_o   = err_parity_q;
    assign err_overflow_o = err_overflow_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_udma_uart_rx_core.sv
// Directed and randomised frames for udma_uart_rx_core, checked against a bit-level
// frame model and timing derived from the divider settings.
module tb_udma_uart_rx_core;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rstn, rx, en, pen, stop2, ready;
    logic [15:0] div;
    logic [1:0]  bits;
    logic [7:0]  data;
    logic        valid, eparity, eovf, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    udma_uart_rx_core #(
        .SYNC_STAGES(SYNC),
        .DIV_WIDTH  (16)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .rx_i           (rx),
        .cfg_en_i       (en),
        .cfg_div_i      (div),
        .cfg_bits_i     (bits),
        .cfg_parity_en_i(pen),
        .cfg_stop_bits_i(stop2),
        .rx_data_o      (data),
        .rx_valid_o     (valid),
        .rx_ready_i     (ready),
        .err_parity_o   (eparity),
        .err_overflow_o (eovf),
        .busy_o         (busy)
    );

    // Event monitor: counts valid edges and error pulses, enforces pulse width and stability.
    logic       valid_prev = 1'b0, par_prev = 1'b0, ovf_prev = 1'b0, ready_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    int rises = 0, falls = 0, par_cnt = 0, ovf_cnt = 0, rise_cyc = 0;

    always @(negedge clk) begin
        if (valid && !valid_prev) begin
            rises++;
            rise_cyc = cyc;
        end
        if (!valid && valid_prev) falls++;
        if (eparity) par_cnt++;
        if (eovf) ovf_cnt++;
        checks++;
        assert (!(eparity && par_prev) && !(eovf && ovf_prev)) else begin
            errors++;
            $error("FAIL pulse_width: parity=%b overflow=%b high two cycles, required one",
                   eparity, eovf);
        end
        if (valid_prev && valid && !ready_prev) begin
            checks++;
            assert (data === data_prev) else begin
                errors++;
                $error("FAIL data_stable: observed 0x%0h expected 0x%0h", data, data_prev);
            end
        end
        valid_prev = valid;
        par_prev   = eparity;
        ovf_prev   = eovf;
        data_prev  = data;
        ready_prev = ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle offset (from driving the start bit) of the first stop-bit sample.
    function automatic int stop_off(input int dv, input int nb, input int pe);
        return SYNC + 1 + (dv >> 1) + (nb + pe + 1) * (dv + 1);
    endfunction

    // Drives a whole frame plus two idle bit periods; optionally pulses ready at one
    // offset and scrambles the config inputs once the frame has started.
    task automatic send_frame(input logic [7:0] d, input int dv, input int nb, input bit pe,
                              input bit flip, input bit stop_ok, input bit two,
                              input int ready_off, input bit scramble);
        logic [15:0] seq;
        logic [7:0]  mask;
        int          p, len, total;
        mask = 8'((1 << nb) - 1);
        seq  = '1;
        seq[0] = 1'b0;
        for (int i = 0; i < nb; i++) seq[1 + i] = d[i];
        p = 1 + nb;
        if (pe) begin
            seq[p] = (^(d & mask)) ^ flip;
            p++;
        end
        seq[p] = stop_ok;
        len   = p + 1 + int'(two);
        total = (len + 2) * (dv + 1);
        div   = 16'(dv);
        bits  = 2'(nb - 5);
        pen   = pe;
        stop2 = two;
        last_start = cyc;
        for (int o = 0; o < total; o++) begin
            rx    = seq[o / (dv + 1)];
            ready = (o == ready_off);
            if (scramble && o == SYNC + 3) begin
                div   = 16'($urandom_range(3, 40));
                bits  = 2'($urandom_range(0, 3));
                pen   = 1'($urandom_range(0, 1));
                stop2 = 1'($urandom_range(0, 1));
            end
            step(1);
        end
        ready = 1'b0;
    endtask

    task automatic consume(input string tag);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        chk(tag, valid, 1'b0);
    endtask

    int r0, f0, p0, v0;

    initial begin
        rstn = 1'b0; rx = 1'b1; en = 1'b1; ready = 1'b0;
        div = 16'd15; bits = 2'd3; pen = 1'b0; stop2 = 1'b0;
        step(3);
        chk("reset_data", data, 8'h00);
        chk("reset_valid", valid, 1'b0);
        chk("reset_errs", {eparity, eovf}, 2'b00);
        chk("reset_busy", busy, 1'b0);
        rstn = 1'b1;
        step(5);

        // 8N1 0xA5 with exact delivery latency
        r0 = rises;
        send_frame(8'hA5, 15, 8, 0, 0, 1, 0, -1, 0);
        chk("a5_rises", 32'(rises - r0), 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_latency", 32'(rise_cyc - last_start), 32'(stop_off(15, 8, 0) + 1));
        consume("a5_consume");

        // 5-bit, even parity, two stop bits
        p0 = par_cnt; r0 = rises;
        send_frame(8'h13, 15, 5, 1, 0, 1, 1, -1, 0);
        chk("p5_data", data, 8'h13);
        chk("p5_rises", 32'(rises - r0), 1);
        chk("p5_no_perr", 32'(par_cnt - p0), 0);
        consume("p5_consume");
        p0 = par_cnt;
        send_frame(8'h13, 15, 5, 1, 1, 1, 1, -1, 0);
        chk("p5bad_data", data, 8'h13);
        chk("p5bad_perr", 32'(par_cnt - p0), 1);
        consume("p5bad_consume");

        // Overflow: second character dropped (with its parity error still flagged)
        r0 = rises; p0 = par_cnt; v0 = ovf_cnt;
        send_frame(8'h11, 15, 8, 1, 0, 1, 0, -1, 0);
        send_frame(8'h22, 15, 8, 1, 1, 1, 0, -1, 0);
        chk("ovf_rises", 32'(rises - r0), 1);
        chk("ovf_data", data, 8'h11);
        chk("ovf_pulse", 32'(ovf_cnt - v0), 1);
        chk("ovf_perr", 32'(par_cnt - p0), 1);
        f0 = falls; v0 = ovf_cnt;
        send_frame(8'h33, 15, 8, 0, 0, 1, 0, stop_off(15, 8, 0), 0);
        chk("swap_data", data, 8'h33);
        chk("swap_valid", valid, 1'b1);
        chk("swap_no_fall", 32'(falls - f0), 0);
        chk("swap_no_ovf", 32'(ovf_cnt - v0), 0);
        consume("swap_consume");

        // False start glitch
        r0 = rises;
        rx = 1'b0;
        step(4);
        chk("glitch_busy_hi", busy, 1'b1);
        rx = 1'b1;
        step(20);
        chk("glitch_busy_lo", busy, 1'b0);
        chk("glitch_rises", 32'(rises - r0), 0);

        // Framing error
        r0 = rises; p0 = par_cnt; v0 = ovf_cnt;
        send_frame(8'h5C, 15, 8, 0, 0, 0, 0, -1, 0);
        chk("frame_rises", 32'(rises - r0), 0);
        chk("frame_pulses", 32'((par_cnt - p0) + (ovf_cnt - v0)), 0);
        chk("frame_busy", busy, 1'b0);

        // Disable mid-DATA
        r0 = rises;
        rx = 1'b0; step(16);
        rx = 1'b1; step(16);
        rx = 1'b0; step(20);
        chk("dis_busy_hi", busy, 1'b1);
        en = 1'b0;
        step(1);
        chk("dis_busy_lo", busy, 1'b0);
        rx = 1'b1;
        step(40);
        en = 1'b1;
        step(5);
        chk("dis_no_rise", 32'(rises - r0), 0);
        send_frame(8'h5A, 15, 8, 0, 0, 1, 0, -1, 0);
        chk("reen_data", data, 8'h5A);
        chk("reen_rises", 32'(rises - r0), 1);

        // Synchronous reset mid-frame with 0x5A still pending
        rx = 1'b0;
        step(30);
        chk("rst_pending", valid, 1'b1);
        rstn = 1'b0;
        step(1);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_errs", {eparity, eovf}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        rx = 1'b1;
        step(3);
        rstn = 1'b1;
        step(5);
        send_frame(8'h3C, 15, 8, 0, 0, 1, 0, -1, 0);
        chk("post_rst_data", data, 8'h3C);
        chk("post_rst_valid", valid, 1'b1);
        consume("post_rst_consume");

        // Random formats; config inputs scrambled mid-frame must not matter
        for (int i = 0; i < 8; i++) begin
            int         dv, nb;
            bit         pe, fl, two;
            logic [7:0] d, exp_d;
            dv  = $urandom_range(3, 20);
            nb  = $urandom_range(5, 8);
            pe  = 1'($urandom_range(0, 1));
            fl  = pe & 1'($urandom_range(0, 1));
            two = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            exp_d = d & 8'((1 << nb) - 1);
            r0 = rises; p0 = par_cnt; v0 = ovf_cnt;
            send_frame(d, dv, nb, pe, fl, 1, two, -1, 1);
            chk("rnd_data", data, exp_d);
            chk("rnd_rises", 32'(rises - r0), 1);
            chk("rnd_perr", 32'(par_cnt - p0), 32'(fl));
            chk("rnd_ovf", 32'(ovf_cnt - v0), 0);
            chk("rnd_latency", 32'(rise_cyc - last_start), 32'(stop_off(dv, nb, int'(pe)) + 1));
            consume("rnd_consume");
        end

        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_uart_rx_core.md
Name: udma_uart_rx_core

Overview:
- UART receive engine directly upstream of the UART register/config interface.
- Synchronises and deserialises the serial `rx_i` line, using divider, frame-format and enable settings from the config registers.
- Delivers each received character through a one-entry valid/ready holding register to the register interface's polling/IRQ data path.
- Reports single-cycle parity-error and overflow pulses.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `rx_i` synchroniser (minimum 2).
- DIV_WIDTH, 16, width of the bit-period divider.

Ports:
- clk_i  input  1  clock; the block uses this single clock.
- rstn_i  input  1  reset, synchronous to `clk_i`, active-low.
- rx_i  input  1  asynchronous serial line; idle level is high.
- cfg_en_i  input  1  receiver enable.
- cfg_div_i  input  DIV_WIDTH  bit period = `cfg_div_i`+1 clock cycles; legal values ≥ 3.
- cfg_bits_i  input  2  data bits per character = 5 + `cfg_bits_i` (0→5 … 3→8).
- cfg_parity_en_i  input  1  1 = an even-parity bit follows the data bits.
- cfg_stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits.
- rx_data_o  output  8  received character, LSB-aligned; unused upper bits are 0.
- rx_valid_o  output  1  `rx_data_o` holds an unconsumed character.
- rx_ready_i  input  1  consumer accepts `rx_data_o` in a cycle where both valid and ready are high.
- err_parity_o  output  1  one-cycle pulse on a parity mismatch.
- err_overflow_o  output  1  one-cycle pulse when a character is dropped.
- busy_o  output  1  FSM is not in IDLE.

Behaviour:
- Reset (`rstn_i`=0 at a clock edge): all outputs are 0 (`rx_data_o`=0x00). Synchroniser flops reset to 1. FSM goes to IDLE; counters are cleared.
- Synchroniser: the sampled line `s_rx` is `rx_i` delayed by SYNC_STAGES cycles. All decisions use `s_rx` only.
- Config latch: div, bits, parity_en and stop_bits are captured on the IDLE→START transition. Config changes mid-frame take effect from the next frame.
- Bit counter: counts 0..div_latched and restarts at 0; a "tick" occurs when the count reaches the target.
- FSM states and transitions:
  - IDLE: when `cfg_en_i`=1 and `s_rx` falls (previous value 1, current value 0), go to START with count=0.
  - START: wait `div_latched`>>1 cycles (mid-bit).
    - `s_rx`=0 → go to DATA, count=0, bit index=0.
    - `s_rx`=1 → false start; go to IDLE with no output.
  - DATA: sample `s_rx` at each full-period tick and shift it in LSB-first.
    - After the (5+bits)th sample, go to PARITY if parity is enabled, else go to STOP.
  - PARITY: sample at the tick and compare with the even parity of the data bits (XOR of data and parity bit must be 0). Go to STOP.
  - STOP: sample at the tick.
    - Sampled 1: the character is delivered in the next cycle, together with `err_parity_o` if a mismatch was recorded.
    - Sampled 0: framing error; the character is discarded, no pulses, go to IDLE.
    - Next state is STOP2 if two stop bits are configured, else IDLE.
  - STOP2: wait one full period without checking the line, then go to IDLE.
- Delivery (cycle after the first stop-bit sample):
  - `rx_valid_o`=0, or `rx_valid_o`=1 with `rx_ready_i`=1 in the delivery cycle: load `rx_data_o` with the new character; `rx_valid_o`=1.
  - `rx_valid_o`=1 with `rx_ready_i`=0: keep the old data; pulse `err_overflow_o`; the new character is lost.
  - `err_parity_o` is also pulsed for a mismatched character that is dropped on overflow.
- Handshake: valid&ready with no delivery in the same cycle → `rx_valid_o`=0 next cycle. `rx_data_o` is stable while valid is high.
- Disable: `cfg_en_i`=0 in any state → FSM goes to IDLE next cycle. A partial character is discarded with no pulses; the holding register is untouched.
- Error outputs: `err_parity_o` and `err_overflow_o` are high for exactly one cycle per event and never held.
- `busy_o` = (state != IDLE), registered with the state.

Test Plan:
- div=15, 8N1, send 0xA5 → exactly one `rx_valid_o` rise, `rx_data_o`=0xA5. Valid rises 1 cycle after the stop sample (stop sample is 8+16·9 cycles after the synchronised start edge). Ready pulse → valid low the next cycle.
- div=15, bits=0 (5-bit), parity on, two stop bits, send 0x13 with correct parity → `rx_data_o`=0x13, no error. Repeat with the parity bit flipped → data 0x13, one-cycle `err_parity_o`.
- Hold `rx_ready_i`=0, send 0x11 then 0x22 → `rx_data_o` stays 0x11, one `err_overflow_o` pulse at the second delivery. Assert ready in the delivery cycle of a third byte 0x33 → `rx_data_o`=0x33, valid stays 1, no overflow.
- Framing and false-start checks:
  - 4-cycle low glitch on `rx_i` with div=15 → no valid, `busy_o` returns to 0.
  - Stop bit forced low → no valid, no error pulses.
- Deassert `cfg_en_i` mid-DATA → `busy_o`=0 next cycle, no delivery. Re-enable and send 0x5A → 0x5A received correctly.
- Synchronous reset asserted mid-frame with valid pending → all outputs 0 on the next edge; the first frame after release is received correctly.
